// File: rtl/mips_cpu_multdiv.sv
// Sequential HI/LO multiply/divide unit: 32-step shift-add multiply and restoring divide on operand magnitudes,
// with a final sign-fix cycle. Define MULTDIV_FAST_MULT_EN for single-cycle MULT/MULTU; divides stay sequential.
module mips_cpu_multdiv (
    input  logic        clk,
    input  logic        reset,
    input  logic        clk_enable,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        mthi,
    input  logic        mtlo,
    input  logic [31:0] wdata,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        busy,
    output logic        done
);

    typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

    state_t      state_reg, state_next;
    logic [4:0]  cnt_reg, cnt_next;
    logic [63:0] acc_reg, acc_next;
    logic [31:0] opnd_reg, opnd_next;
    logic        neg_q_reg, neg_q_next;
    logic        neg_r_reg, neg_r_next;
    logic        is_div_reg, is_div_next;
    logic        div_zero_reg, div_zero_next;
    logic [31:0] hi_reg, hi_next;
    logic [31:0] lo_reg, lo_next;
    logic        done_reg, done_next;

    // Operand conditioning: signed ops work on magnitudes and remember the signs.
    logic        is_signed, sign_a, sign_b;
    logic [31:0] mag_a, mag_b;
    assign is_signed = ~op[0];
    assign sign_a    = is_signed & a[31];
    assign sign_b    = is_signed & b[31];
    assign mag_a     = sign_a ? (~a + 32'd1) : a;
    assign mag_b     = sign_b ? (~b + 32'd1) : b;

    // One multiply step: conditionally add multiplicand into upper half, shift right.
    logic [32:0] mul_sum;
    assign mul_sum = {1'b0, acc_reg[63:32]} + {1'b0, opnd_reg};

    // One restoring-divide step: bring next dividend bit into the partial remainder and trial-subtract.
    logic [32:0] div_trial;
    assign div_trial = acc_reg[63:31] - {1'b0, opnd_reg};

    logic [31:0] quot_fixed, rem_fixed;
    logic [63:0] prod_fixed;
    assign quot_fixed = neg_q_reg ? (~acc_reg[31:0] + 32'd1) : acc_reg[31:0];
    assign rem_fixed  = neg_r_reg ? (~acc_reg[63:32] + 32'd1) : acc_reg[63:32];
    assign prod_fixed = neg_q_reg ? (~acc_reg + 64'd1) : acc_reg;

`ifdef MULTDIV_FAST_MULT_EN
    logic [63:0] fast_prod;
    always_comb begin
        if (is_signed)
            fast_prod = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
        else
            fast_prod = {32'd0, a} * {32'd0, b};
    end
`endif

    always_comb begin
        state_next    = state_reg;
        cnt_next      = cnt_reg;
        acc_next      = acc_reg;
        opnd_next     = opnd_reg;
        neg_q_next    = neg_q_reg;
        neg_r_next    = neg_r_reg;
        is_div_next   = is_div_reg;
        div_zero_next = div_zero_reg;
        hi_next       = hi_reg;
        lo_next       = lo_reg;
        done_next     = 1'b0;

        case (state_reg)
            IDLE: begin
                if (start) begin
`ifdef MULTDIV_FAST_MULT_EN
                    if (!op[1]) begin
                        hi_next   = fast_prod[63:32];
                        lo_next   = fast_prod[31:0];
                        done_next = 1'b1;
                    end else begin
`else
                    begin
`endif
                        state_next    = RUN;
                        cnt_next      = 5'd0;
                        is_div_next   = op[1];
                        neg_q_next    = sign_a ^ sign_b;
                        neg_r_next    = sign_a;
                        div_zero_next = (b == 32'd0);
                        // Multiply shifts the multiplier out of the low half; divide shifts the dividend out.
                        opnd_next     = op[1] ? mag_b : mag_a;
                        acc_next      = op[1] ? {32'd0, mag_a} : {32'd0, mag_b};
                    end
                end else begin
                    if (mthi) hi_next = wdata;
                    if (mtlo) lo_next = wdata;
                end
            end

            RUN: begin
                cnt_next = cnt_reg + 5'd1;
                if (is_div_reg) begin
                    if (!div_trial[32])
                        acc_next = {div_trial[31:0], acc_reg[30:0], 1'b1};
                    else
                        acc_next = {acc_reg[62:0], 1'b0};
                end else begin
                    if (acc_reg[0])
                        acc_next = {mul_sum, acc_reg[31:1]};
                    else
                        acc_next = {1'b0, acc_reg[63:1]};
                end
                if (cnt_reg == 5'd31)
                    state_next = FIX;
            end

            FIX: begin
                if (is_div_reg) begin
                    // Zero divisor yields an all-ones quotient; remainder already equals the dividend.
                    lo_next = div_zero_reg ? 32'hFFFF_FFFF : quot_fixed;
                    hi_next = rem_fixed;
                end else begin
                    hi_next = prod_fixed[63:32];
                    lo_next = prod_fixed[31:0];
                end
                done_next  = 1'b1;
                state_next = IDLE;
            end

            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg    <= IDLE;
            cnt_reg      <= 5'd0;
            acc_reg      <= 64'd0;
            opnd_reg     <= 32'd0;
            neg_q_reg    <= 1'b0;
            neg_r_reg    <= 1'b0;
            is_div_reg   <= 1'b0;
            div_zero_reg <= 1'b0;
            hi_reg       <= 32'd0;
            lo_reg       <= 32'd0;
            done_reg     <= 1'b0;
        end else if (clk_enable) begin
            state_reg    <= state_next;
            cnt_reg      <= cnt_next;
            acc_reg      <= acc_next;
            opnd_reg     <= opnd_next;
            neg_q_reg    <= neg_q_next;
            neg_r_reg    <= neg_r_next;
            is_div_reg   <= is_div_next;
            div_zero_reg <= div_zero_next;
            hi_reg       <= hi_next;
            lo_reg       <= lo_next;
            done_reg     <= done_next;
        end
    end

    assign hi   = hi_reg;
    assign lo   = lo_reg;
    assign busy = (state_reg != IDLE);
    assign done = done_reg;

endmodule

// File: doc/mips_cpu_multdiv.md
MIPS_CPU_MULTDIV -- requirements
Module: mips_cpu_multdiv

Interface
REQ-001 Ports SHALL be, in order: clk  in  1  system clock; reset  in  1  synchronous, active-high reset.
REQ-002 clk_enable  in  1  global advance enable; when 0 all state SHALL hold.
REQ-003 start  in  1  launch request for the operation on op, a and b.
REQ-004 op  in  2  operation code: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
REQ-005 a, b  in  32 each  operands (rs, rt) from the register-file read ports.
REQ-006 mthi, mtlo  in  1 each  direct HI/LO write strobes; wdata  in  32  write value.
REQ-007 hi, lo  out  32 each  architectural HI/LO registers, consumed by MFHI/MFLO result selection.
REQ-008 busy  out  1  operation in flight; drives the datapath stall input.
REQ-009 done  out  1  single-cycle pulse marking the cycle in which new HI/LO are first visible.
REQ-010 Clock SHALL be clk and reset SHALL be reset, with one clock domain and a synchronous, active-high reset.

Function
REQ-011 FSM states SHALL be IDLE, RUN and FIX; all transitions SHALL occur only on clk edges where clk_enable=1.
REQ-012 In IDLE, start=1 SHALL latch the operand magnitudes, sign flags and op; it SHALL clear a 5-bit counter; and it SHALL enter RUN.
REQ-013 RUN SHALL perform one shift-add multiply step or one restoring-divide step per cycle for exactly 32 cycles, with the counter wrapping 31->0, and then SHALL enter FIX.
REQ-014 FIX SHALL apply the sign correction and write hi/lo, then SHALL return to IDLE with done=1 for exactly one cycle.
REQ-015 Latency: hi/lo SHALL be updated on the 34th enabled edge after the start edge. busy SHALL be 1 from the start edge until that edge. done SHALL be 1 in the following cycle only.
REQ-016 MULT/MULTU: {hi,lo} SHALL be the full 64-bit product, signed or unsigned respectively.
REQ-017 DIV/DIVU: lo SHALL be the quotient and hi the remainder. Signed quotients SHALL truncate toward zero. A signed remainder SHALL take the dividend's sign.
REQ-018 Divide by zero SHALL complete with normal latency and give lo=32'hFFFFFFFF and hi=a; no exception is raised.
REQ-019 DIV 32'h80000000 / 32'hFFFFFFFF SHALL give lo=32'h80000000, hi=0.
REQ-020 start while busy=1 SHALL be ignored.
REQ-021 mthi/mtlo in IDLE SHALL load wdata into hi/lo on the next enabled edge; if both are 1, both registers are written.
REQ-022 mthi/mtlo while busy=1, or in the same cycle as an accepted start, SHALL be ignored.
REQ-023 hi/lo SHALL keep their old values during RUN and FIX until the FIX edge.
REQ-024 clk_enable=0 mid-operation SHALL freeze the counter and state without losing progress; done SHALL NOT be re-asserted on resume.

Reset
REQ-025 reset=1 on an edge SHALL force IDLE and set hi=0, lo=0, busy=0, done=0 and counter=0, regardless of clk_enable.
REQ-026 Reset during RUN or FIX SHALL abort the operation with no hi/lo update.

Configuration
REQ-027 With macro MULTDIV_FAST_MULT_EN defined, MULT/MULTU SHALL complete in one cycle: hi/lo are written on the start edge, done=1 in the next cycle, and busy stays 0.
REQ-028 With MULTDIV_FAST_MULT_EN undefined, multiplies SHALL use the 34-cycle sequential path of REQ-013..015.
REQ-029 Divides SHALL always be sequential, with or without MULTDIV_FAST_MULT_EN.

Verification
REQ-030 MULT a=32'hFFFFFFFE (-2), b=3 -> hi=32'hFFFFFFFF, lo=32'hFFFFFFFA, done after 34 edges (1 edge when MULTDIV_FAST_MULT_EN is defined).
REQ-031 MULTU a=b=32'hFFFFFFFF -> hi=32'hFFFFFFFE, lo=32'h00000001.
REQ-032 DIV a=-7, b=2 -> lo=32'hFFFFFFFD (-3), hi=32'hFFFFFFFF (-1); DIVU a=7, b=0 -> lo=32'hFFFFFFFF, hi=7.
REQ-033 Start DIVU 100/7, assert reset at edge 10 -> hi=lo=0, busy=0; a new DIVU 100/7 then gives lo=14, hi=2.
REQ-034 While busy, pulse start with other operands and pulse mthi with wdata=32'h1234 -> both ignored; the original result is delivered unchanged.
REQ-035 In IDLE, mtlo with wdata=32'hCAFE -> lo=32'hCAFE next cycle, hi unchanged; hold clk_enable=0 for 5 cycles mid-DIV -> result is delayed by exactly 5 edges and is correct.
